// File: rtl/sdram_size_probe.sv
// Memory presence/size detector: writes alias signatures, reads them back, reports
// the detected size and optionally clears the detected range. One instance per channel.
module sdram_size_probe #(
  parameter int unsigned ADDR_W     = 27,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BASE_LOG2  = 25,
  parameter int unsigned PROBE_N    = 2,
  parameter int unsigned SIG_BASE   = 1032,
  parameter int unsigned SIG_STEP   = 1032,
  parameter int unsigned DUMMY_VAL  = 12345,
  parameter int unsigned CLEAR_EN   = 1,
  parameter int unsigned FILL_VAL   = 0,
  parameter int unsigned TIMEOUT_W  = 16,
  parameter int unsigned AUTO_START = 1
) (
  input  logic              clk_sys,
  input  logic              RESET,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              present,
  output logic [PROBE_N:0]  probe_ok,
  output logic [5:0]        size_log2,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned JW = (PROBE_N < 1) ? 1 : $clog2(PROBE_N + 1);
  localparam int unsigned CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY_INIT, S_WR_PROBE, S_WR_DUMMY, S_RD_PROBE, S_EVAL, S_CLEAR, S_DONE
  } state_t;

  // Each command is STROBE (one cycle), GAP (ready ignored), then WAIT for ready.
  typedef enum logic [1:0] {PH_WAIT, PH_STROBE, PH_GAP} phase_t;

  state_t              state;
  phase_t              phase;
  logic [JW-1:0]       idx;
  logic [PROBE_N:0]    match;
  logic [CW-1:0]       clr_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                auto_pend;
  logic                waiting;
  logic                rdy_hit;
  logic                tmo_hit;
  logic                clear_end;

  function automatic logic [ADDR_W-1:0] probe_addr(input logic [JW-1:0] j);
    if (j == '0) return '0;
    return ADDR_W'(1) << (BASE_LOG2 + 32'(j) - 1);
  endfunction

  function automatic logic [DATA_W-1:0] sig(input logic [JW-1:0] j);
    return DATA_W'(SIG_BASE + 32'(j) * SIG_STEP);
  endfunction

  // Size grows only while the probes above address 0 match contiguously.
  function automatic logic [5:0] eval_size(input logic [PROBE_N:0] m);
    int unsigned k;
    logic        run;
    k   = 0;
    run = 1'b1;
    for (int unsigned j = 1; j <= PROBE_N; j++) begin
      if (run && m[j]) k = j;
      else run = 1'b0;
    end
    return m[0] ? 6'(BASE_LOG2 + k) : 6'd0;
  endfunction

  always_comb begin
    waiting   = (phase == PH_WAIT) &&
                (state inside {S_WAIT_RDY_INIT, S_WR_PROBE, S_WR_DUMMY, S_RD_PROBE, S_CLEAR});
    rdy_hit   = waiting && mem_ready;
    tmo_hit   = waiting && !mem_ready && (tmo_cnt == '1);
    clear_end = (clr_cnt == (CW'(1) << size_log2));
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state     <= S_IDLE;
      phase     <= PH_WAIT;
      idx       <= '0;
      match     <= '0;
      clr_cnt   <= '0;
      tmo_cnt   <= '0;
      auto_pend <= (AUTO_START != 0);
      mem_addr  <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      mem_rd    <= 1'b0;
      present   <= 1'b0;
      probe_ok  <= '0;
      size_log2 <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_rd <= 1'b0;
      case (phase)
        PH_STROBE: phase <= PH_GAP;
        PH_GAP:    phase <= PH_WAIT;
        default:   ;
      endcase
      if (waiting && !mem_ready) tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      else                       tmo_cnt <= '0;

      if (tmo_hit) begin
        state     <= S_DONE;
        present   <= 1'b0;
        probe_ok  <= '0;
        size_log2 <= '0;
        timeout   <= 1'b1;
        busy      <= 1'b0;
        done      <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start || auto_pend) begin
              auto_pend <= 1'b0;
              match     <= '0;
              present   <= 1'b0;
              probe_ok  <= '0;
              size_log2 <= '0;
              timeout   <= 1'b0;
              done      <= 1'b0;
              busy      <= 1'b1;
              phase     <= PH_WAIT;
              state     <= S_WAIT_RDY_INIT;
            end
          end
          S_WAIT_RDY_INIT: begin
            if (rdy_hit) begin
              idx      <= JW'(PROBE_N);
              mem_we   <= 1'b1;
              mem_addr <= probe_addr(JW'(PROBE_N));
              mem_din  <= sig(JW'(PROBE_N));
              phase    <= PH_STROBE;
              state    <= S_WR_PROBE;
            end
          end
          S_WR_PROBE: begin
            if (rdy_hit) begin
              mem_we <= 1'b1;
              phase  <= PH_STROBE;
              if (idx != '0) begin
                idx      <= idx - JW'(1);
                mem_addr <= probe_addr(idx - JW'(1));
                mem_din  <= sig(idx - JW'(1));
              end else begin
                // Discharge the data bus so a floating bus cannot echo a signature.
                mem_addr <= ADDR_W'(1) << (BASE_LOG2 - 1);
                mem_din  <= DATA_W'(DUMMY_VAL);
                state    <= S_WR_DUMMY;
              end
            end
          end
          S_WR_DUMMY: begin
            if (rdy_hit) begin
              idx      <= JW'(PROBE_N);
              mem_rd   <= 1'b1;
              mem_addr <= probe_addr(JW'(PROBE_N));
              phase    <= PH_STROBE;
              state    <= S_RD_PROBE;
            end
          end
          S_RD_PROBE: begin
            if (rdy_hit) begin
              match[idx] <= (mem_dout == sig(idx));
              if (idx != '0) begin
                idx      <= idx - JW'(1);
                mem_rd   <= 1'b1;
                mem_addr <= probe_addr(idx - JW'(1));
                phase    <= PH_STROBE;
              end else begin
                state <= S_EVAL;
              end
            end
          end
          S_EVAL: begin
            present   <= match[0];
            probe_ok  <= match;
            size_log2 <= eval_size(match);
            phase     <= PH_WAIT;
            if ((CLEAR_EN != 0) && match[0]) begin
              clr_cnt <= '0;
              state   <= S_CLEAR;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
          S_CLEAR: begin
            if (rdy_hit) begin
              if (clear_end) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                mem_we   <= 1'b1;
                mem_addr <= clr_cnt[ADDR_W-1:0];
                mem_din  <= DATA_W'(FILL_VAL);
                clr_cnt  <= clr_cnt + CW'(1);
                phase    <= PH_STROBE;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_size_probe.sv
// Scoreboard bench for sdram_size_probe: two instances (full-size defaults without clear,
// and a small configuration with clear) each driven by an aliasing memory model.
module tb_sdram_size_probe;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Instance A: default geometry, no clear sweep
  logic        reset_a, start_a, we_a, rd_a, ready_a, present_a, busy_a, done_a, tmo_a;
  logic [26:0] addr_a;
  logic [15:0] din_a, dout_a;
  logic [2:0]  ok_a;
  logic [5:0]  size_a;

  // Instance B: BASE_LOG2=4, ADDR_W=7, short timeout, clear enabled
  logic        reset_b, start_b, we_b, rd_b, ready_b, present_b, busy_b, done_b, tmo_b;
  logic [6:0]  addr_b;
  logic [15:0] din_b, dout_b;
  logic [2:0]  ok_b;
  logic [5:0]  size_b;

  sdram_size_probe #(.CLEAR_EN(0)) dut_a (
    .clk_sys(clk_sys), .RESET(reset_a), .start(start_a),
    .mem_addr(addr_a), .mem_din(din_a), .mem_we(we_a), .mem_rd(rd_a),
    .mem_ready(ready_a), .mem_dout(dout_a),
    .present(present_a), .probe_ok(ok_a), .size_log2(size_a),
    .busy(busy_a), .done(done_a), .timeout(tmo_a)
  );

  sdram_size_probe #(.ADDR_W(7), .BASE_LOG2(4), .TIMEOUT_W(4)) dut_b (
    .clk_sys(clk_sys), .RESET(reset_b), .start(start_b),
    .mem_addr(addr_b), .mem_din(din_b), .mem_we(we_b), .mem_rd(rd_b),
    .mem_ready(ready_b), .mem_dout(dout_b),
    .present(present_b), .probe_ok(ok_b), .size_log2(size_b),
    .busy(busy_b), .done(done_b), .timeout(tmo_b)
  );

  // Memory models: addresses fold modulo 2^msize; ready drops for two cycles per command.
  int          msize_a, msize_b, lat_a, lat_b;
  bit          float_a, float_b, stuck_a, stuck_b;
  logic [15:0] last_a, last_b;
  logic [15:0] mem_a [4];
  logic [15:0] mem_b [128];

  function automatic int slot_a(input logic [26:0] a);
    logic [26:0] m;
    m = a & 27'((64'd1 << msize_a) - 64'd1);
    if (m[26]) return 3;
    if (m[25]) return 2;
    if (m[24]) return 1;
    return 0;
  endfunction

  function automatic logic [6:0] slot_b(input logic [6:0] a);
    return a & 7'((32'd1 << msize_b) - 32'd1);
  endfunction

  always @(posedge clk_sys) begin
    if (lat_a > 0) lat_a <= lat_a - 1;
    if (we_a) begin
      mem_a[slot_a(addr_a)] <= din_a;
      last_a <= din_a;
      lat_a  <= 2;
    end
    if (rd_a) begin
      dout_a <= float_a ? last_a : mem_a[slot_a(addr_a)];
      lat_a  <= 2;
    end
    if (lat_b > 0) lat_b <= lat_b - 1;
    if (we_b) begin
      mem_b[slot_b(addr_b)] <= din_b;
      last_b <= din_b;
      lat_b  <= 2;
    end
    if (rd_b) begin
      dout_b <= float_b ? last_b : mem_b[slot_b(addr_b)];
      lat_b  <= 2;
    end
  end
  assign ready_a = !stuck_a && (lat_a == 0);
  assign ready_b = !stuck_b && (lat_b == 0);

  // Scoreboard
  typedef struct packed { logic rd; logic [31:0] addr; logic [15:0] data; } cmd_t;
  typedef struct packed { logic present; logic [2:0] ok; logic [5:0] size; logic tmo; } res_t;
  cmd_t qc_a[$], qc_b[$];
  res_t qr_a[$], qr_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   b_we_cnt = 0;
  logic pd_a = 1'b0;
  logic pd_b = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic push_cmd(input bit b, input bit rd, input int unsigned addr, input int unsigned data);
    cmd_t c;
    c.rd   = rd;
    c.addr = addr;
    c.data = 16'(data);
    if (b) qc_b.push_back(c);
    else   qc_a.push_back(c);
  endtask

  // Probe sequence for dummy address `base`: probes live at 4*base, 2*base and 0.
  task automatic push_probe(input bit b, input int unsigned base);
    push_cmd(b, 0, base * 4, 3096);
    push_cmd(b, 0, base * 2, 2064);
    push_cmd(b, 0, 0,        1032);
    push_cmd(b, 0, base,     12345);
    push_cmd(b, 1, base * 4, 0);
    push_cmd(b, 1, base * 2, 0);
    push_cmd(b, 1, 0,        0);
  endtask

  task automatic push_res(input bit b, input bit p, input logic [2:0] ok, input int unsigned sz, input bit t);
    res_t r;
    r.present = p;
    r.ok      = ok;
    r.size    = 6'(sz);
    r.tmo     = t;
    if (b) qr_b.push_back(r);
    else   qr_a.push_back(r);
  endtask

  task automatic push_clear_b(input int unsigned words);
    for (int unsigned i = 0; i < words; i++) push_cmd(1, 0, i, 0);
  endtask

  always @(negedge clk_sys) begin
    if (we_a || rd_a) begin
      if (qc_a.size() == 0) check("A_unexpected_cmd", 64'({we_a, rd_a, addr_a}), 64'd0);
      else begin
        check("A_cmd", 64'({rd_a, 32'(addr_a), rd_a ? 16'h0 : din_a}),
              64'({qc_a[0].rd, qc_a[0].addr, qc_a[0].rd ? 16'h0 : qc_a[0].data}));
        qc_a.delete(0);
      end
    end
    if (done_a && !pd_a) begin
      if (qr_a.size() == 0) check("A_unexpected_done", 64'(done_a), 64'd0);
      else begin
        check("A_result", 64'({present_a, ok_a, size_a, tmo_a, busy_a}),
              64'({qr_a[0].present, qr_a[0].ok, qr_a[0].size, qr_a[0].tmo, 1'b0}));
        qr_a.delete(0);
      end
    end
    pd_a <= done_a;
    if (we_b) b_we_cnt <= b_we_cnt + 1;
    if (we_b || rd_b) begin
      if (qc_b.size() == 0) check("B_unexpected_cmd", 64'({we_b, rd_b, addr_b}), 64'd0);
      else begin
        check("B_cmd", 64'({rd_b, 32'(addr_b), rd_b ? 16'h0 : din_b}),
              64'({qc_b[0].rd, qc_b[0].addr, qc_b[0].rd ? 16'h0 : qc_b[0].data}));
        qc_b.delete(0);
      end
    end
    if (done_b && !pd_b) begin
      if (qr_b.size() == 0) check("B_unexpected_done", 64'(done_b), 64'd0);
      else begin
        check("B_result", 64'({present_b, ok_b, size_b, tmo_b, busy_b}),
              64'({qr_b[0].present, qr_b[0].ok, qr_b[0].size, qr_b[0].tmo, 1'b0}));
        qr_b.delete(0);
      end
    end
    pd_b <= done_b;
  end

  task automatic pulse_start(input bit b);
    @(negedge clk_sys);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk_sys);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int max, input string name);
    int n;
    n = 0;
    while (!(b ? done_b : done_a) && n < max) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, 64'(b ? done_b : done_a), 64'd1);
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wait_b_writes(input int target, input string name);
    int n;
    n = 0;
    while (b_we_cnt < target && n < 400) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, 64'(b_we_cnt >= target), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    reset_a = 1'b1; reset_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    msize_a = 25; float_a = 1'b0; stuck_a = 1'b0;
    msize_b = 5;  float_b = 1'b0; stuck_b = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("A_reset_outs", 64'({we_a, rd_a, present_a, ok_a, size_a, busy_a, done_a, tmo_a, addr_a, din_a}), 64'd0);
    check("B_reset_outs", 64'({we_b, rd_b, present_b, ok_b, size_b, busy_b, done_b, tmo_b, addr_b, din_b}), 64'd0);

    // A: 2^25-word device, both upper probes fold onto address 0
    push_probe(0, 32'h0100_0000);
    push_res(0, 1, 3'b001, 25, 0);
    reset_a = 1'b0;
    @(negedge clk_sys);
    check("A_busy_after_autostart", 64'(busy_a), 64'd1);
    wait_done(0, 300, "A_done_25");

    // A: 2^26-word device
    msize_a = 26;
    push_probe(0, 32'h0100_0000);
    push_res(0, 1, 3'b011, 26, 0);
    pulse_start(0);
    wait_done(0, 300, "A_done_26");

    // A: 2^27-word device spans the whole port
    msize_a = 27;
    push_probe(0, 32'h0100_0000);
    push_res(0, 1, 3'b111, 27, 0);
    pulse_start(0);
    wait_done(0, 300, "A_done_27");
    check("A_queues_empty", 64'(qc_a.size() + qr_a.size()), 64'd0);

    // B: 2^5-word device, clear sweep of 32 words; a start while busy must be ignored
    push_probe(1, 8);
    push_clear_b(32);
    push_res(1, 1, 3'b011, 5, 0);
    reset_b = 1'b0;
    wait_b_writes(2, "B_reach_probe_writes");
    pulse_start(1);
    wait_done(1, 2000, "B_done_clear");
    repeat (5) @(negedge clk_sys);
    check("B_done_sticky", 64'({done_b, busy_b}), 64'b10);
    check("B_queues_empty_1", 64'(qc_b.size() + qr_b.size()), 64'd0);

    // B: restart, then reset (with a coincident start) in the middle of the clear sweep
    push_probe(1, 8);
    push_clear_b(32);
    push_res(1, 1, 3'b011, 5, 0);
    n = b_we_cnt;
    pulse_start(1);
    wait_b_writes(n + 14, "B_reach_clear");
    reset_b = 1'b1;
    start_b = 1'b1;
    @(negedge clk_sys);
    check("B_reset_mid_clear", 64'({we_b, rd_b, present_b, ok_b, size_b, busy_b, done_b, tmo_b, addr_b, din_b}), 64'd0);
    qc_b.delete();
    qr_b.delete();
    @(negedge clk_sys);
    start_b = 1'b0;
    push_probe(1, 8);
    push_clear_b(32);
    push_res(1, 1, 3'b011, 5, 0);
    reset_b = 1'b0;
    wait_done(1, 2000, "B_done_after_reset");

    // B: floating data bus reads back the dummy value everywhere
    float_b = 1'b1;
    push_probe(1, 8);
    push_res(1, 0, 3'b000, 0, 0);
    pulse_start(1);
    wait_done(1, 500, "B_done_float");
    repeat (10) @(negedge clk_sys);
    float_b = 1'b0;

    // B: ready stuck low, 16-cycle timeout then abort with no commands
    stuck_b = 1'b1;
    push_res(1, 0, 3'b000, 0, 1);
    @(negedge clk_sys);
    start_b = 1'b1;
    @(negedge clk_sys);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("B_timeout_latency", 64'(n), 64'd16);
    repeat (10) @(negedge clk_sys);
    check("B_timeout_flags", 64'({done_b, tmo_b, busy_b, present_b}), 64'b1100);
    check("B_queues_empty_2", 64'(qc_b.size() + qr_b.size()), 64'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/sdram_size_probe.md
Name: sdram_size_probe

Overview:
- Parametrised memory presence/size detector and background clearer for one SDRAM (or DDR) command port.
- After reset it probes power-of-two alias addresses with distinct signatures and reports presence, a per-probe match mask and detected size.
- It then optionally clears the detected range.
- One instance is used per memory channel (primary/secondary SDRAM). Results feed the menu's status mask.

Parameters:
ADDR_W, 27, word address width of memory port
DATA_W, 16, data width of memory port
BASE_LOG2, 25, log2 (words) of smallest supported device; dummy write goes to 2^(BASE_LOG2-1)
PROBE_N, 2, number of alias probes above address 0 (probe j at 2^(BASE_LOG2+j-1), j=1..PROBE_N); requires BASE_LOG2+PROBE_N-1 < ADDR_W
SIG_BASE, 1032, signature of probe 0
SIG_STEP, 1032, signature increment per probe index (SIG(j)=SIG_BASE+j*SIG_STEP mod 2^DATA_W)
DUMMY_VAL, 12345, bus-discharge value
CLEAR_EN, 1, run clear sweep after successful probe
FILL_VAL, 0, clear data
TIMEOUT_W, 16, ready-wait timeout = 2^TIMEOUT_W cycles
AUTO_START, 1, start probe automatically when leaving reset

Ports:
clk_sys  in  1  clock
RESET  in  1  synchronous, active-high reset
start  in  1  pulse; restarts probe when idle/done
mem_addr  out  ADDR_W  command address
mem_din  out  DATA_W  write data
mem_we  out  1  one-cycle write strobe
mem_rd  out  1  one-cycle read strobe
mem_ready  in  1  controller idle; mem_dout valid when high after a read
mem_dout  in  DATA_W  read data
present  out  1  probe 0 matched
probe_ok  out  PROBE_N+1  per-probe match mask, bit j = probe j
size_log2  out  6  detected size in log2 words, 0 if absent
busy  out  1  probe or clear in progress
done  out  1  sequence finished (sticky until restart/reset)
timeout  out  1  aborted on ready timeout

Behaviour:
- Reset: RESET is synchronous, active-high, clocked on clk_sys. All outputs go to 0 at the next edge, including strobes, even mid-command. State goes to IDLE. If AUTO_START=1, the probe begins on the first cycle after RESET deasserts.
- States:
  - IDLE.
  - WAIT_RDY_INIT: wait for mem_ready.
  - WR_PROBE: j = PROBE_N down to 0.
  - WR_DUMMY.
  - RD_PROBE: j = PROBE_N down to 0.
  - EVAL.
  - CLEAR.
  - DONE.
- Command rule: a strobe is issued for exactly one cycle, with addr/din valid in that cycle. The next cycle is a mandatory gap, and mem_ready is ignored during it. The FSM then waits for mem_ready=1 before the next command. At most one command is in flight.
- Write order: highest probe first, address 0 last. Smaller addresses therefore overwrite aliases of larger ones. The dummy write (DUMMY_VAL at 2^(BASE_LOG2-1)) follows the probe writes.
- Reads: read data is sampled on the first cycle mem_ready=1 after the read gap. probe_ok[j] <= (mem_dout == SIG(j)).
- EVAL, one cycle:
  - present = probe_ok[0].
  - size_log2 = BASE_LOG2 + k, where k is the largest value with probe_ok[1..k] all 1 (k=0 allowed).
  - If present=0, size_log2=0.
- CLEAR (CLEAR_EN=1 and present=1): write FILL_VAL to addresses 0 .. 2^size_log2-1, ascending.
  - The address counter is ADDR_W+1 bits wide and terminates at 2^size_log2. It does not wrap into address 0.
  - If size_log2 = ADDR_W, the sweep covers the whole port.
- Otherwise the FSM goes from EVAL straight to DONE.
- Timeout: a TIMEOUT_W counter runs in every ready-wait state and clears when mem_ready=1. On overflow the FSM aborts to DONE with timeout=1, present=0, probe_ok=0, size_log2=0.
- busy=1 in every state except IDLE/DONE. done=1 only in DONE.
- start:
  - Honoured in IDLE or DONE: it clears done, timeout and results, then enters WAIT_RDY_INIT.
  - Ignored while busy.
  - start coincident with RESET: RESET wins.
- Results are updated only in EVAL/abort. They are stable throughout CLEAR and DONE.

Test Plan:
- Aliased model, 2^25 words (2^25 and 2^26 fold to 0), defaults -> probe_ok=3'b001, present=1, size_log2=25; clear writes exactly 2^25 words of 0 (use CLEAR_EN=0 or a small BASE_LOG2 for runtime).
- 2^26-word model -> probe_ok=3'b011, size_log2=26; 2^27-word model -> probe_ok=3'b111, size_log2=27; command order checked as writes 2^26, 2^25, 0, dummy 2^24, then reads 2^26, 2^25, 0.
- BASE_LOG2=4, PROBE_N=2, ADDR_W=7, model 2^5 words -> size_log2=5, exactly 32 FILL_VAL writes at addresses 0..31, no write at 32, done=1.
- mem_ready stuck 0, TIMEOUT_W=4 -> timeout=1 after 16 wait cycles, present=0, done=1, no further strobes.
- Data bus floating (reads return last-written DUMMY_VAL) -> present=0, probe_ok=0, size_log2=0, no clear writes.
- RESET asserted mid-CLEAR -> next edge all outputs 0, no strobe; after release the probe reruns and gives the same results. start pulsed while busy is ignored; start in DONE reruns the probe.
